// File: rtl/mem_dp_pipe_if.sv
// Write/read port bundle for the simple-dual-port staging buffer.
// The master drives requests; the slave (the buffer) returns read data and status.
interface mem_dp_pipe_if #(
   parameter int WIDTH  = 64,
   parameter int ADDR_W = 32
);
   logic                 wr_en;
   logic [ADDR_W-1:0]    wr_addr;
   logic [WIDTH-1:0]     wr_data;
   logic [WIDTH/8-1:0]   wr_be;
   logic                 rd_en;
   logic [ADDR_W-1:0]    rd_addr;
   logic [WIDTH-1:0]     rd_data;
   logic                 rd_valid;
   logic                 oob_err;

   modport master (
      output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      input  rd_data, rd_valid, oob_err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      output rd_data, rd_valid, oob_err
   );
endinterface

// File: rtl/mem_dp_pipe.sv
// Simple-dual-port buffer with byte-enable writes, RD_LAT-deep read pipeline,
// selectable read-during-write policy and a sticky out-of-range flag.
module mem_dp_pipe #(
   parameter int WIDTH   = 64,
   parameter int LENGTH  = 4096,
   parameter int ADDR_W  = 32,
   parameter int RD_LAT  = 1,
   parameter int RDW_NEW = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_dp_pipe_if.slave bus
);
   localparam int BE_W  = WIDTH / 8;
   localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

   if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
      $fatal(1, "mem_dp_pipe: WIDTH must be a non-zero multiple of 8");
   end
   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
      $fatal(1, "mem_dp_pipe: RD_LAT must be in 1..4");
   end
   if (ADDR_W < 63 && (64'd1 << ADDR_W) < 64'(LENGTH)) begin : g_bad_addr
      $fatal(1, "mem_dp_pipe: ADDR_W too narrow for LENGTH");
   end

   logic [WIDTH-1:0] mem_q [LENGTH];
   logic [RD_LAT-1:0] vld_q;
   logic [WIDTH-1:0]  dat_q [RD_LAT];
   logic              oob_q, oob_d;

   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic              wr_in_rng, rd_in_rng, wr_fire, rd_hit;
   logic [WIDTH-1:0]  be_mask, wr_word, rd_word_d;

   assign wr_in_rng = 64'(bus.wr_addr) < 64'(LENGTH);
   assign rd_in_rng = 64'(bus.rd_addr) < 64'(LENGTH);
   assign wr_idx    = bus.wr_addr[IDX_W-1:0];
   assign rd_idx    = bus.rd_addr[IDX_W-1:0];
   assign wr_fire   = bus.wr_en && wr_in_rng;
   assign rd_hit    = wr_fire && (bus.rd_addr == bus.wr_addr);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      be_mask = '0;
      for (int i = 0; i < BE_W; i++) begin
         be_mask[8*i +: 8] = {8{bus.wr_be[i]}};
      end
   end

   // Post-write word, used only to forward a same-address write into the read.
   assign wr_word = (mem_q[wr_idx] & ~be_mask) | (bus.wr_data & be_mask);

   always_comb begin
      rd_word_d = '0;
      if (rd_in_rng) begin
         rd_word_d = (RDW_NEW != 0 && rd_hit) ? wr_word : mem_q[rd_idx];
      end
   end

   assign oob_d = oob_q | (bus.wr_en && !wr_in_rng) | (bus.rd_en && !rd_in_rng);

   // NOTE: the storage array has no reset; contents survive rst_n so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int i = 0; i < BE_W; i++) begin
            if (bus.wr_be[i]) mem_q[wr_idx][8*i +: 8] <= bus.wr_data[8*i +: 8];
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every stage sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
         oob_q <= 1'b0;
      end else begin
         vld_q[0] <= bus.rd_en;
         if (bus.rd_en) dat_q[0] <= rd_word_d;
         // Data stages load only behind a valid, so rd_data holds between results.
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
         end
         oob_q <= oob_d;
      end
   end

   assign bus.rd_valid = vld_q[RD_LAT-1];
   assign bus.rd_data  = dat_q[RD_LAT-1];
   assign bus.oob_err  = oob_q;
endmodule

// File: tb/tb_mem_dp_pipe.sv
// Drives four buffer instances (latency 2/2/1/4, new/old/new/new read-during-write)
// with shared directed stimulus and checks them against a cycle-indexed model.
module tb_mem_dp_pipe;
   localparam int WIDTH  = 32;
   localparam int LENGTH = 16;
   localparam int ADDR_W = 32;
   localparam int NDUT   = 4;
   localparam int MAXC   = 1024;
   localparam int LATS [NDUT] = '{2, 2, 1, 4};
   localparam int NEWS [NDUT] = '{1, 0, 1, 1};

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wr_en = 1'b0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_be = '0;
   logic        rd_en = 1'b0;
   logic [31:0] rd_addr = '0;

   logic        rdv [NDUT];
   logic [31:0] rdd [NDUT];
   logic        oob [NDUT];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      mem_dp_pipe_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus_if ();
      assign bus_if.wr_en   = wr_en;
      assign bus_if.wr_addr = wr_addr;
      assign bus_if.wr_data = wr_data;
      assign bus_if.wr_be   = wr_be;
      assign bus_if.rd_en   = rd_en;
      assign bus_if.rd_addr = rd_addr;
      assign rdv[g] = bus_if.rd_valid;
      assign rdd[g] = bus_if.rd_data;
      assign oob[g] = bus_if.oob_err;

      mem_dp_pipe #(
         .WIDTH(WIDTH), .LENGTH(LENGTH), .ADDR_W(ADDR_W),
         .RD_LAT(LATS[g]), .RDW_NEW(NEWS[g])
      ) u_dut (
         .clk(clk),
         .rst_n(rst_n),
         .bus(bus_if.slave)
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: word array plus, per sampling edge, whether a read was issued and
   // what it returns under each read-during-write policy.
   bit [31:0] m_mem [LENGTH];
   bit        iss_v [MAXC];
   bit [31:0] res_old [MAXC];
   bit [31:0] res_new [MAXC];
   bit        m_oob = 1'b0;
   bit [31:0] last_d [NDUT];
   int        cyc = -1;
   bit        chk_on = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
      if (cyc < MAXC) begin
         iss_v[cyc] = 1'b0;
         if (rst_n) begin
            if (rd_en) res_old[cyc] = (rd_addr < LENGTH) ? m_mem[rd_addr[3:0]] : 32'h0;
            if (wr_en) begin
               if (wr_addr < LENGTH) begin
                  for (int b = 0; b < 4; b++)
                     if (wr_be[b]) m_mem[wr_addr[3:0]][8*b +: 8] = wr_data[8*b +: 8];
               end else begin
                  m_oob = 1'b1;
               end
            end
            if (rd_en) begin
               res_new[cyc] = (rd_addr < LENGTH) ? m_mem[rd_addr[3:0]] : 32'h0;
               if (rd_addr >= LENGTH) m_oob = 1'b1;
               iss_v[cyc] = 1'b1;
            end
         end
      end
   end

   // Reset drops every read still in flight and clears the flag and held data.
   initial forever begin
      @(negedge rst_n);
      for (int k = 0; k < MAXC; k++) iss_v[k] = 1'b0;
      m_oob = 1'b0;
      for (int d = 0; d < NDUT; d++) last_d[d] = '0;
   end

   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         for (int d = 0; d < NDUT; d++) begin
            int        k;
            bit        ev;
            bit [31:0] ed;
            k  = cyc - LATS[d] + 1;
            ev = (k >= 0 && k < MAXC) ? iss_v[k] : 1'b0;
            ed = ev ? ((NEWS[d] != 0) ? res_new[k] : res_old[k]) : last_d[d];
            last_d[d] = ed;
            check($sformatf("rd_valid[%0d]", d), {31'd0, rdv[d]}, {31'd0, ev});
            check($sformatf("rd_data[%0d]", d), rdd[d], ed);
            check($sformatf("oob_err[%0d]", d), {31'd0, oob[d]}, {31'd0, m_oob});
         end
      end
   end

   // Streaming monitor: first valid cycle, first data and pulse count per instance.
   bit        mon_on = 1'b0;
   int        first [NDUT];
   int        cnt [NDUT];
   bit [31:0] first_d [NDUT];

   initial forever begin
      @(negedge clk);
      if (mon_on) begin
         for (int d = 0; d < NDUT; d++) begin
            if (rdv[d] === 1'b1) begin
               if (first[d] < 0) begin
                  first[d]   = cyc;
                  first_d[d] = rdd[d];
               end
               cnt[d]++;
            end
         end
      end
   end

   // Inputs applied here are sampled at the next rising edge.
   task automatic drive(input bit we, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input bit re, input logic [31:0] ra);
      @(posedge clk);
      #1;
      wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
      rd_en = re; rd_addr = ra;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   // One access with a read, then a hand-computed check on the two latency-2 instances.
   task automatic access_lit(input bit we, input logic [31:0] wa, input logic [31:0] wd,
                             input logic [3:0] be, input logic [31:0] ra,
                             input logic [31:0] exp_new, input logic [31:0] exp_old,
                             input string name);
      drive(we, wa, wd, be, 1'b1, ra);
      idle(2);
      check({name, " valid"}, {31'd0, rdv[0]}, 32'd1);
      check({name, " new"}, rdd[0], exp_new);
      check({name, " old"}, rdd[1], exp_old);
   endtask

   initial begin
      int e0;
      #1 rst_n = 1'b0;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("reset rd_valid[%0d]", d), {31'd0, rdv[d]}, 32'd0);
         check($sformatf("reset rd_data[%0d]", d), rdd[d], 32'd0);
         check($sformatf("reset oob_err[%0d]", d), {31'd0, oob[d]}, 32'd0);
      end
      chk_on = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Fill, then stream reads back-to-back.
      for (int k = 0; k < LENGTH; k++) drive(1'b1, k, 32'h1000_0000 + k, 4'hF, 1'b0, '0);
      for (int d = 0; d < NDUT; d++) begin
         first[d] = -1;
         cnt[d]   = 0;
      end
      mon_on = 1'b1;
      e0 = 0;
      for (int k = 0; k < LENGTH; k++) begin
         drive(1'b0, '0, '0, '0, 1'b1, k);
         if (k == 1) e0 = cyc;
      end
      idle(8);
      mon_on = 1'b0;
      check("stream latency lat2 new", first[0] - e0 + 1, 32'd2);
      check("stream latency lat2 old", first[1] - e0 + 1, 32'd2);
      check("stream latency lat1", first[2] - e0 + 1, 32'd1);
      check("stream latency lat4", first[3] - e0 + 1, 32'd4);
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("stream pulses[%0d]", d), cnt[d], 32'd16);
         check($sformatf("stream first data[%0d]", d), first_d[d], 32'h1000_0000);
      end

      // Byte enables.
      drive(1'b1, 32'd3, 32'hAABB_CCDD, 4'hF, 1'b0, '0);
      drive(1'b1, 32'd3, 32'h1122_3344, 4'b0101, 1'b0, '0);
      drive(1'b1, 32'd4, 32'h5555_5555, 4'h0, 1'b0, '0);
      access_lit(1'b0, '0, '0, '0, 32'd3, 32'hAA22_CC44, 32'hAA22_CC44, "byte enable");
      access_lit(1'b0, '0, '0, '0, 32'd4, 32'h1000_0004, 32'h1000_0004, "be zero no-op");

      // Read-during-write, same and different addresses.
      drive(1'b1, 32'd5, 32'h0, 4'hF, 1'b0, '0);
      access_lit(1'b1, 32'd5, 32'hDEAD_BEEF, 4'hF, 32'd5, 32'hDEAD_BEEF, 32'h0, "rdw same");
      access_lit(1'b0, '0, '0, '0, 32'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "rdw after");
      access_lit(1'b1, 32'd6, 32'h0123_4567, 4'hF, 32'd7, 32'h1000_0007, 32'h1000_0007, "rdw diff");

      // Out of range.
      check("oob clear before", {31'd0, oob[0]}, 32'd0);
      drive(1'b1, 32'd16, 32'hFFFF_FFFF, 4'hF, 1'b0, '0);
      idle(1);
      check("oob after write", {31'd0, oob[0]}, 32'd1);
      for (int k = 0; k < LENGTH; k++) drive(1'b0, '0, '0, '0, 1'b1, k);
      access_lit(1'b0, '0, '0, '0, 32'd0, 32'h1000_0000, 32'h1000_0000, "array intact");
      access_lit(1'b0, '0, '0, '0, 32'd20, 32'h0, 32'h0, "oob read");
      idle(3);
      check("oob sticky", {31'd0, oob[3]}, 32'd1);

      // Reset with reads in flight.
      drive(1'b0, '0, '0, '0, 1'b1, 32'd0);
      drive(1'b0, '0, '0, '0, 1'b1, 32'd1);
      drive(1'b0, '0, '0, '0, 1'b1, 32'd2);
      idle(1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("mid reset rd_valid[%0d]", d), {31'd0, rdv[d]}, 32'd0);
         check($sformatf("mid reset oob_err[%0d]", d), {31'd0, oob[d]}, 32'd0);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);
      access_lit(1'b0, '0, '0, '0, 32'd3, 32'hAA22_CC44, 32'hAA22_CC44, "post reset read");
      check("post reset oob", {31'd0, oob[0]}, 32'd0);

      idle(6);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
